// File: rtl/lfsr_prng_gen.sv
// Fibonacci LFSR word generator with leapfrog stepping,
// seed loading, warm-up discard and a valid/ready output.
module lfsr_prng_gen #(
  parameter int                WIDTH  = 32,
  parameter logic [WIDTH-1:0]  TAPS   = WIDTH'(32'hB89ADA1C),
  parameter int                STEP   = 1,
  parameter logic [WIDTH-1:0]  SEED   = WIDTH'(32'hAAAAAAAA),
  parameter int                WARMUP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             seed_err
);

  typedef enum logic {
    WARM,
    RUN
  } state_t;

  localparam state_t      INIT_S = (WARMUP == 0) ? RUN : WARM;
  localparam logic        INIT_V = (WARMUP == 0);
  localparam logic [15:0] WLAST  =
    16'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_t      state;
  logic [15:0] wcnt;
  logic        seed_zero;
  logic [WIDTH-1:0] nxt;

  // STEP single shifts folded into one combinational advance
  function automatic logic [WIDTH-1:0] adv(
    input logic [WIDTH-1:0] s
  );
    logic [WIDTH-1:0] r;
    r = s;
    for (int k = 0; k < STEP; k++) begin
      r = {r[WIDTH-2:0], ^(r & TAPS)};
    end
    return r;
  endfunction

  assign seed_zero = (seed_in == '0);
  assign nxt       = adv(q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= SEED;
      wcnt      <= '0;
      seed_err  <= 1'b0;
      state     <= INIT_S;
      out_valid <= INIT_V;
    end else begin
      seed_err <= 1'b0;
      if (seed_load) begin
        q         <= seed_zero ? SEED : seed_in;
        seed_err  <= seed_zero;
        wcnt      <= '0;
        state     <= INIT_S;
        out_valid <= INIT_V;
      end else begin
        unique case (state)
          WARM: begin
            q <= nxt;
            if (wcnt == WLAST) begin
              wcnt      <= '0;
              state     <= RUN;
              out_valid <= 1'b1;
            end else begin
              wcnt <= wcnt + 16'd1;
            end
          end
          RUN: begin
            if (out_ready) q <= nxt;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Bench for lfsr_prng_gen: three parameterisations checked
// against a remaining-discards reference model.
module tb_lfsr_prng_gen;

  localparam logic [31:0] TAPSV = 32'hB89ADA1C;
  localparam logic [31:0] SEEDV = 32'hAAAAAAAA;

  logic clk;
  logic rst;
  logic        ld  [3];
  logic [31:0] sd  [3];
  logic        rdy [3];
  logic        v   [3];
  logic [31:0] q   [3];
  logic        e   [3];

  int checks = 0;
  int errors = 0;

  int stp [3] = '{1, 2, 1};
  int wrm [3] = '{0, 0, 4};

  typedef struct {
    logic [31:0] q;
    int          left;
    bit          err;
  } mdl_t;

  mdl_t m [3];

  lfsr_prng_gen u0 (
    .clk(clk), .rst(rst), .seed_load(ld[0]),
    .seed_in(sd[0]), .out_ready(rdy[0]),
    .out_valid(v[0]), .q(q[0]), .seed_err(e[0])
  );

  lfsr_prng_gen #(.STEP(2)) u1 (
    .clk(clk), .rst(rst), .seed_load(ld[1]),
    .seed_in(sd[1]), .out_ready(rdy[1]),
    .out_valid(v[1]), .q(q[1]), .seed_err(e[1])
  );

  lfsr_prng_gen #(.WARMUP(4)) u2 (
    .clk(clk), .rst(rst), .seed_load(ld[2]),
    .seed_in(sd[2]), .out_ready(rdy[2]),
    .out_valid(v[2]), .q(q[2]), .seed_err(e[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n successive single-bit shifts, feedback by tap parity
  function automatic logic [31:0] succ(
    input logic [31:0] x, input int n
  );
    logic [31:0] r;
    int          c;
    r = x;
    for (int s = 0; s < n; s++) begin
      c = 0;
      for (int i = 0; i < 32; i++)
        if (TAPSV[i] && r[i]) c++;
      r = (r << 1) | 32'(c % 2);
    end
    return r;
  endfunction

  function automatic mdl_t mstep(
    input mdl_t x, input int step, input int warm,
    input bit l, input logic [31:0] s, input bit r
  );
    mdl_t n;
    n = x;
    n.err = 0;
    if (l) begin
      n.q    = (s == 0) ? SEEDV : s;
      n.err  = (s == 0);
      n.left = warm;
    end else if (x.left > 0) begin
      n.q    = succ(x.q, step);
      n.left = x.left - 1;
    end else if (r) begin
      n.q = succ(x.q, step);
    end
    return n;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      m[i].q    = SEEDV;
      m[i].left = wrm[i];
      m[i].err  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], stp[i], wrm[i],
                   ld[i], sd[i], rdy[i]);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ld[i]  = 1'b0;
      sd[i]  = '0;
      rdy[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mreset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q[i] !== SEEDV || v[i] !== (wrm[i] == 0)
          || e[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d q=%h v=%b e=%b need %h %b 0",
                 i, q[i], v[i], e[i], SEEDV, wrm[i] == 0);
      end
    end
    rst = 1'b0;
    mreset();
  endtask

  task automatic test_legacy_seq();
    do_reset();
    rdy[0] = 1'b1;
    tick();
    checks++;
    if (q[0] !== 32'h55555554 || v[0] !== 1'b1) begin
      errors++;
      $display("FAIL legacy1 q=%h v=%b need 55555554 1",
               q[0], v[0]);
    end
    tick();
    checks++;
    if (q[0] !== 32'hAAAAAAA8 || v[0] !== 1'b1) begin
      errors++;
      $display("FAIL legacy2 q=%h v=%b need aaaaaaa8 1",
               q[0], v[0]);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (q[0] !== SEEDV || v[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold c%0d q=%h v=%b need %h 1",
                 c, q[0], v[0], SEEDV);
      end
    end
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    checks++;
    if (q[0] !== 32'h55555554) begin
      errors++;
      $display("FAIL hold_accept q=%h need 55555554", q[0]);
    end
  endtask

  task automatic test_step2();
    do_reset();
    rdy[1] = 1'b1;
    tick();
    checks++;
    if (q[1] !== 32'hAAAAAAA8) begin
      errors++;
      $display("FAIL step2_1 q=%h need aaaaaaa8", q[1]);
    end
    tick();
    checks++;
    if (q[1] !== succ(SEEDV, 4)) begin
      errors++;
      $display("FAIL step2_2 q=%h need %h",
               q[1], succ(SEEDV, 4));
    end
    rdy[1] = 1'b0;
  endtask

  task automatic test_seed_load();
    do_reset();
    ld[0] = 1'b1;
    sd[0] = 32'h0;
    tick();
    ld[0] = 1'b0;
    checks++;
    if (q[0] !== SEEDV || e[0] !== 1'b1) begin
      errors++;
      $display("FAIL seed_zero q=%h e=%b need %h 1",
               q[0], e[0], SEEDV);
    end
    tick();
    checks++;
    if (e[0] !== 1'b0) begin
      errors++;
      $display("FAIL seed_err_pulse e=%b need 0", e[0]);
    end
    ld[0] = 1'b1;
    sd[0] = 32'h12345678;
    tick();
    ld[0] = 1'b0;
    checks++;
    if (q[0] !== 32'h12345678 || e[0] !== 1'b0) begin
      errors++;
      $display("FAIL seed_nz q=%h e=%b need 12345678 0",
               q[0], e[0]);
    end
    ld[0]  = 1'b1;
    rdy[0] = 1'b1;
    sd[0]  = 32'hCAFEF00D;
    tick();
    ld[0]  = 1'b0;
    rdy[0] = 1'b0;
    checks++;
    if (q[0] !== 32'hCAFEF00D || v[0] !== 1'b1) begin
      errors++;
      $display("FAIL seed_hs q=%h v=%b need cafef00d 1",
               q[0], v[0]);
    end
  endtask

  task automatic test_warmup();
    do_reset();
    checks++;
    if (v[2] !== 1'b0 || q[2] !== SEEDV) begin
      errors++;
      $display("FAIL warm0 v=%b q=%h need 0 %h",
               v[2], q[2], SEEDV);
    end
    for (int c = 1; c <= 4; c++) begin
      rdy[2] = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (v[2] !== (c == 4) || q[2] !== succ(SEEDV, c)) begin
        errors++;
        $display("FAIL warm%0d v=%b q=%h need %b %h",
                 c, v[2], q[2], c == 4, succ(SEEDV, c));
      end
    end
    rdy[2] = 1'b0;
    tick();
    checks++;
    if (v[2] !== 1'b1 || q[2] !== succ(SEEDV, 4)) begin
      errors++;
      $display("FAIL warm_hold v=%b q=%h need 1 %h",
               v[2], q[2], succ(SEEDV, 4));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rdy[0] = 1'b1;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (q[2] !== SEEDV || v[2] !== 1'b0
        || q[0] !== SEEDV || v[0] !== 1'b1) begin
      errors++;
      $display("FAIL async q0=%h v0=%b q2=%h v2=%b need %h 1 %h 0",
               q[0], v[0], q[2], v[2], SEEDV, SEEDV);
    end
    rst = 1'b0;
    mreset();
    rdy[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (v[2] !== (c == 4) || q[2] !== succ(SEEDV, c)) begin
        errors++;
        $display("FAIL rewarm%0d v=%b q=%h need %b %h",
                 c, v[2], q[2], c == 4, succ(SEEDV, c));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        rdy[i] = 1'($urandom_range(0, 1));
        ld[i]  = ($urandom_range(0, 15) == 0);
        sd[i]  = ($urandom_range(0, 3) == 0) ? 32'h0
                                               : $urandom;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q[i] !== m[i].q || v[i] !== (m[i].left == 0)
            || e[i] !== m[i].err || q[i] === 32'h0) begin
          errors++;
          $display("FAIL rand c%0d u%0d q=%h v=%b e=%b need %h %b %b",
                   c, i, q[i], v[i], e[i], m[i].q,
                   m[i].left == 0, m[i].err);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    mreset();
    test_reset();
    test_legacy_seq();
    test_hold();
    test_step2();
    test_seed_load();
    test_warmup();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_prng_gen.md
# lfsr_prng_gen

Parametrised Fibonacci-LFSR pseudo-random word generator, the next generation of the team's 32-bit uniform PRNG. It adds configurable width and tap mask, multi-bit leapfrog stepping, run-time seed loading with all-zero lockup protection, a warm-up discard phase, and a valid/ready output handshake. It feeds stochastic/dither consumers that pull one word per transaction.

## Interface
- WIDTH, 32: LFSR and output width, 3..64.
- TAPS, 32'hB89ADA1C: feedback mask. Bit i set means q[i] is in the XOR; must be WIDTH bits with bit WIDTH-1 set.
- STEP, 1: single-bit shifts applied per advance, 1..WIDTH. All shifts happen in one clock.
- SEED, 32'hAAAAAAAA: reset state, also the substitute for an all-zero seed; nonzero.
- WARMUP, 0: advances discarded after reset or seed load before out_valid rises, 0..65535.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- seed_load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  new seed.
- out_ready  in  1  consumer accepts q.
- out_valid  out  1  q holds a fresh word.
- q  out  WIDTH  current LFSR state, the output word.
- seed_err  out  1  one-cycle pulse: loaded seed was zero and was replaced by SEED.

## Operation
- Single step: fb = XOR of q[i] for every set bit i of TAPS. Next q = {q[WIDTH-2:0], fb}.
- Advance: STEP single steps composed combinationally. With STEP=1 this is the legacy behaviour.
- States are WARM and RUN. out_valid is 1 exactly in RUN.
- WARM: advance every cycle and increment wcnt. When wcnt reaches WARMUP-1 on an advance, go to RUN next cycle. Handshake is ignored.
- RUN: advance only on out_valid && out_ready. No advance otherwise; q is held stable while valid.
- seed_load, in any state, has priority over advance and handshake:
  - next q = seed_in, or SEED if seed_in == 0.
  - If seed_in == 0, seed_err = 1 for that next cycle, else 0.
  - wcnt is cleared. State goes to WARM if WARMUP > 0, else RUN.
- A handshake coincident with seed_load completes: the consumer took the old q. No advance is applied.
- q never becomes zero, because TAPS gives a nonzero-preserving map for a nonzero state. The bench asserts q != 0 always.

## Timing
- Reset values:
  - q = SEED, wcnt = 0, seed_err = 0.
  - State = RUN and out_valid = 1 if WARMUP == 0; otherwise State = WARM and out_valid = 0.
- Reset release mid-warm-up restarts the warm-up from zero.
- Latency:
  - The handshake on edge N shows the next word on q after edge N; out_valid stays 1. This gives one word per cycle when out_ready is held high.
  - seed_load on edge N puts the seed on q after edge N.
  - With WARMUP = W > 0, out_valid rises after edge N+W. q then equals the seed advanced W times.
- wcnt is 16 bits. WARMUP = 0 bypasses WARM entirely.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Defaults, release reset, out_ready = 1:
  - q = AAAAAAAA, out_valid = 1.
  - Next cycles show 55555554, then AAAAAAA8.
- Defaults with out_ready = 0 for 5 cycles, then 1 for one cycle:
  - q holds AAAAAAAA for all 5 cycles.
  - q becomes 55555554 after the accepting edge.
- STEP = 2, out_ready = 1: the sequence after reset is AAAAAAAA, AAAAAAA8 (every second legacy word).
- seed_load with seed_in = 0:
  - Next cycle q = AAAAAAAA and seed_err = 1 for exactly one cycle.
  - seed_in = 12345678 instead gives q = 12345678 and seed_err = 0.
- WARMUP = 4, defaults otherwise:
  - out_valid = 0 for 4 cycles after reset release while q steps AAAAAAAA, 55555554, AAAAAAA8, ...
  - out_valid rises with q equal to the 4th successor. out_ready has no effect before that.
- Assert rst mid-WARM and mid-RUN:
  - q returns to AAAAAAAA asynchronously, out_valid follows the reset value, and warm-up restarts.
  - Check seed_load coincident with a handshake: q = seed, with no extra advance.
